quad_adc_deserializer: RTL and testbench

Parametrised successor to the quad ADC serial interface. It recovers CHANNELS parallel ADC samples from LANES serial lanes per channel, using a frame marker sampled in the bit-clock domain. It adds frame-lock qualification, misalignment detection, a saturating frame-error counter and a per-word valid strobe. It sits between the ADC LVDS input buffers and the sample FIFO / correlation logic.

---
 rtl/quad_adc_deserializer.sv | 140 ++++++++++++++
 tb/tb_quad_adc_deserializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_adc_deserializer.sv
// Quad ADC deserializer: rebuilds CHANNELS x BITS parallel samples from LANES serial lanes
// per channel, using a frame marker sampled on the bit clock to qualify alignment.

// Per-channel assembly: each word bit is owned by a fixed (slot, lane) pair, MSB first.
module qad_chan_asm #(
   parameter int BITS  = 14,
   parameter int LANES = 2,
   parameter int SW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap,
   input  logic [SW-1:0]    slot,
   input  logic [LANES-1:0] ser,
   output logic [BITS-1:0]  word
);
   logic [BITS-1:0] acc_q, acc_d;

   for (genvar b = 0; b < BITS; b++) begin : g_bit
      localparam int SB = (BITS - 1 - b) / LANES;
      localparam int LB = (BITS - 1 - b) % LANES;
      assign acc_d[b] = (slot == SB[SW-1:0]) ? ser[LB] : acc_q[b];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         word  <= '0;
      end else begin
         acc_q <= acc_d;
         if (cap) word <= acc_d;
      end
   end
endmodule

module quad_adc_deserializer #(
   parameter int CHANNELS   = 4,
   parameter int BITS       = 14,
   parameter int LANES      = 2,
   parameter int SLOTS      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                      DATA_CLK,
   input  logic                      RESET,
   input  logic                      ENABLE,
   input  logic                      FRAME_CLK,
   input  logic [CHANNELS*LANES-1:0] CH_X_SER,
   output logic [CHANNELS*BITS-1:0]  CH_X_DATA,
   output logic                      DATA_VALID,
   output logic                      LOCKED,
   output logic [ERR_WIDTH-1:0]      FRAME_ERRORS
);
   localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [SW-1:0] LAST      = SW'(SLOTS - 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);

   typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKING, ST_LOCKED} state_t;

   state_t                         state;
   logic [CHANNELS-1:0][LANES-1:0] ser_q;
   logic                           frm_q, frm_qq;
   logic [SW-1:0]                  cnt, slot;
   logic [GW-1:0]                  good;
   logic                           frm_edge, wrap, last;

   // cnt holds the slot of the previous sample; slot is the one now in ser_q
   assign frm_edge = frm_q & ~frm_qq;
   assign wrap     = (cnt == LAST);
   assign slot     = (frm_edge || wrap) ? '0 : cnt + 1'b1;
   assign last     = (slot == LAST);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      qad_chan_asm #(.BITS(BITS), .LANES(LANES), .SW(SW)) u_asm (
         .clk  (DATA_CLK),
         .rst  (RESET),
         .cap  (last & ENABLE),
         .slot (slot),
         .ser  (ser_q[c]),
         .word (CH_X_DATA[c*BITS +: BITS])
      );
   end

   always_ff @(posedge DATA_CLK) begin
      if (RESET) begin
         ser_q        <= '0;
         frm_q        <= 1'b0;
         frm_qq       <= 1'b0;
         cnt          <= '0;
         good         <= '0;
         state        <= ST_UNLOCKED;
         DATA_VALID   <= 1'b0;
         LOCKED       <= 1'b0;
         FRAME_ERRORS <= '0;
      end else begin
         ser_q      <= CH_X_SER;
         frm_q      <= FRAME_CLK;
         frm_qq     <= frm_q;
         cnt        <= slot;
         DATA_VALID <= ENABLE && last && (state == ST_LOCKED);
         if (!ENABLE) begin
            state  <= ST_UNLOCKED;
            good   <= '0;
            LOCKED <= 1'b0;
         end else begin
            case (state)
               ST_UNLOCKED: if (frm_edge) begin
                  state <= ST_LOCKING;
                  good  <= '0;
               end
               ST_LOCKING: begin
                  if (frm_edge && wrap) begin
                     if (good == GOOD_LAST) begin
                        state  <= ST_LOCKED;
                        LOCKED <= 1'b1;
                     end else begin
                        good <= good + 1'b1;
                     end
                  end else if (frm_edge || wrap) begin
                     good <= '0;
                  end
               end
               // an edge off the wrap slot, or a wrap with no edge, is a misalignment
               ST_LOCKED: if (frm_edge != wrap) begin
                  if (FRAME_ERRORS != '1) FRAME_ERRORS <= FRAME_ERRORS + 1'b1;
                  state  <= ST_LOCKING;
                  good   <= '0;
                  LOCKED <= 1'b0;
               end
               default: begin
                  state  <= ST_UNLOCKED;
                  good   <= '0;
                  LOCKED <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_quad_adc_deserializer.sv
// Bench for quad_adc_deserializer: default-style instance against a frame-level model,
// plus a BITS=12/LANES=4/SLOTS=3 single-channel instance.
module tb_quad_adc_deserializer;
   localparam int CH = 4, BITS = 14, LANES = 2, SLOTS = 8, LC = 4, EW = 2;
   localparam int W = CH * BITS, NS = CH * LANES, NCYC = 4096;
   localparam int ERR_MAX = (1 << EW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, en, frm;
   logic [NS-1:0] ser;
   logic [W-1:0]  data;
   logic          valid, locked;
   logic [EW-1:0] errs;

   quad_adc_deserializer #(.CHANNELS(CH), .BITS(BITS), .LANES(LANES), .SLOTS(SLOTS),
                           .LOCK_COUNT(LC), .ERR_WIDTH(EW)) u_dut (
      .DATA_CLK(clk), .RESET(rst), .ENABLE(en), .FRAME_CLK(frm), .CH_X_SER(ser),
      .CH_X_DATA(data), .DATA_VALID(valid), .LOCKED(locked), .FRAME_ERRORS(errs));

   logic        a_rst, a_en, a_frm, a_valid, a_locked, a_done;
   logic [3:0]  a_ser;
   logic [11:0] a_data;
   logic [15:0] a_errs;

   quad_adc_deserializer #(.CHANNELS(1), .BITS(12), .LANES(4), .SLOTS(3),
                           .LOCK_COUNT(4), .ERR_WIDTH(16)) u_alt (
      .DATA_CLK(clk), .RESET(a_rst), .ENABLE(a_en), .FRAME_CLK(a_frm), .CH_X_SER(a_ser),
      .CH_X_DATA(a_data), .DATA_VALID(a_valid), .LOCKED(a_locked), .FRAME_ERRORS(a_errs));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // frame-level model: sample index n is the edge that captured it
   int          cyc = 0, n_reg = 0, anchor = -1;
   int          m_state = 0, good = 0, merr = 0;
   bit          f1 = 0, f2 = 0, exp_valid = 0, pad1 = 0;
   logic [W-1:0] exp_data = '0, tx_word;
   logic [W-1:0] txw [NCYC];

   task automatic tick();
      int d;
      bit edge_;
      @(posedge clk);
      if (rst) begin
         m_state = 0; good = 0; merr = 0; exp_valid = 0; exp_data = '0;
         f1 = 0; f2 = 0; n_reg = cyc; anchor = cyc - 1;
      end else begin
         edge_ = f1 && !f2;
         d = (n_reg - anchor) % SLOTS;
         exp_valid = 0;
         if (!en) begin
            m_state = 0; good = 0;
         end else begin
            if (!edge_ && d == SLOTS - 1) begin
               exp_valid = (m_state == 2);
               exp_data  = txw[n_reg % NCYC];
            end
            case (m_state)
               0: if (edge_) begin m_state = 1; good = 0; end
               1: if (edge_ && d == 0) begin
                     good++;
                     if (good == LC) m_state = 2;
                  end else if (edge_ || d == 0) good = 0;
               default: if ((edge_ && d != 0) || (!edge_ && d == 0)) begin
                     if (merr < ERR_MAX) merr++;
                     m_state = 1; good = 0;
                  end
            endcase
         end
         if (edge_) anchor = n_reg;
         f2 = f1; f1 = frm; n_reg = cyc; txw[cyc % NCYC] = tx_word;
      end
      cyc++;
      #1;
      chk("valid", 64'(valid), 64'(exp_valid));
      chk("locked", 64'(locked), 64'(m_state == 2));
      chk("errs", 64'(errs), 64'(merr));
      if (exp_valid) chk("data", 64'(data), 64'(exp_data));
      @(negedge clk);
   endtask

   function automatic logic [NS-1:0] lane_bits(input logic [W-1:0] w, input int p, input bit pad);
      logic [NS-1:0] v;
      logic [W-1:0]  t;
      logic          bt;
      int            idx;
      v = '0;
      for (int c = 0; c < CH; c++)
         for (int l = 0; l < LANES; l++) begin
            idx = BITS - 1 - (p * LANES + l);
            if (p < SLOTS && idx >= 0) begin
               t = w >> (c * BITS + idx);
               bt = t[0];
            end else bt = pad ? 1'b1 : 1'($urandom % 2);
            v = v | (NS'(bt) << (c * LANES + l));
         end
      return v;
   endfunction

   task automatic send_frame(input logic [W-1:0] w, input int len, input bit mark);
      for (int p = 0; p < len; p++) begin
         frm = mark && (p < SLOTS / 2);
         ser = lane_bits(w, p, pad1);
         tx_word = w;
         tick();
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   // alternate config: 12'hABC on one channel, 4 lanes, 3 slots
   int a_cyc = 0, a_last = 0, a_nval = 0;
   initial begin
      logic [11:0] t;
      a_rst = 1'b1; a_en = 1'b1; a_frm = 1'b0; a_ser = '0; a_done = 1'b0;
      repeat (3) @(negedge clk);
      a_rst = 1'b0;
      for (int f = 0; f < 20; f++)
         for (int p = 0; p < 3; p++) begin
            a_frm = (p == 0);
            a_ser = '0;
            for (int l = 0; l < 4; l++) begin
               t = 12'hABC >> (11 - (p * 4 + l));
               a_ser = a_ser | (4'(t[0]) << l);
            end
            @(negedge clk);
         end
      a_frm = 1'b0; a_ser = '0;
      repeat (4) @(negedge clk);
      a_done = 1'b1;
   end

   always begin
      @(posedge clk);
      #1;
      a_cyc++;
      if (a_valid) begin
         chk("alt_data", 64'(a_data), 64'h0ABC);
         if (a_nval > 0) chk("alt_gap", 64'(a_cyc - a_last), 64'd3);
         a_last = a_cyc;
         a_nval++;
      end
   end

   initial begin
      logic [W-1:0] held, lane_w;
      int wait_cyc;
      rst = 1'b1; en = 1'b1; frm = 1'b0; ser = '0; tx_word = '0;
      repeat (3) tick();
      chk("rst_data", 64'(data), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_errs", 64'(errs), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) send_frame({CH{14'((i % 7) + 1)}}, SLOTS, 1'b1);
      chk("lock_seq", 64'(locked), 64'd1);
      for (int i = 0; i < 10; i++) send_frame(rnd_word(), SLOTS, 1'b1);

      pad1 = 1'b1;
      lane_w = {14'h0000, 14'h1555, 14'h2AAA, 14'h3FFF};
      for (int i = 0; i < 3; i++) send_frame(lane_w, SLOTS, 1'b1);
      chk("lane_map", 64'(data), 64'(lane_w));
      pad1 = 1'b0;

      // short frame makes the following edge land on slot 5
      for (int e = 1; e <= 5; e++) begin
         send_frame(rnd_word(), 5, 1'b1);
         for (int i = 0; i < 6; i++) send_frame(rnd_word(), SLOTS, 1'b1);
         chk("sat_errs", 64'(errs), 64'((e < ERR_MAX) ? e : ERR_MAX));
         chk("sat_relock", 64'(locked), 64'd1);
      end

      send_frame(rnd_word(), SLOTS, 1'b0);
      for (int i = 0; i < 6; i++) send_frame(rnd_word(), SLOTS, 1'b1);

      send_frame(rnd_word(), 3, 1'b1);
      rst = 1'b1;
      tick();
      chk("mid_rst_data", 64'(data), 64'd0);
      chk("mid_rst_valid", 64'(valid), 64'd0);
      chk("mid_rst_locked", 64'(locked), 64'd0);
      chk("mid_rst_errs", 64'(errs), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) send_frame(rnd_word(), SLOTS, 1'b1);
      chk("relock_rst", 64'(locked), 64'd1);

      held = data;
      en = 1'b0;
      for (int i = 0; i < 3; i++) send_frame(rnd_word(), SLOTS, 1'b1);
      chk("en_hold", 64'(data), 64'(held));
      chk("en_lock", 64'(locked), 64'd0);
      en = 1'b1;
      for (int i = 0; i < 6; i++) send_frame(rnd_word(), SLOTS, 1'b1);
      chk("relock_en", 64'(locked), 64'd1);

      wait_cyc = 0;
      while (!a_done && wait_cyc < 1000) begin
         @(negedge clk);
         wait_cyc++;
      end
      chk("alt_done", 64'(a_done), 64'd1);
      chk("alt_cnt", 64'(a_nval), 64'd16);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
